fractal_sync_node: RTL and testbench

// - 2:1 barrier node of the fractal synchronization tree: joins the sync requests of two children
//   (CUs or lower nodes), then wakes them locally or forwards one merged request to its parent.
// - Level travels one-hot; each node consumes bit 0 and forwards level>>1 upward.

---
 rtl/fractal_sync_node.sv | 148 ++++++++++++++
 tb/tb_fractal_sync_node.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_node.sv
// fractal_sync_node: 2:1 barrier join of two children; wakes them locally or merges one request upward.
// Latency: child wake (or parent sync) two edges after the edge that latches the second arrival.
// Backpressure: sync/wake/ack handshake on every port; requests and wakes are held until acknowledged.
module fractal_sync_node #(
  parameter  int unsigned SLV_WIDTH = 2,
  localparam int unsigned MST_WIDTH = SLV_WIDTH - 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                slv_sync_i,
  input  logic [1:0][SLV_WIDTH-1:0] slv_lvl_i,
  output logic [1:0]                slv_wake_o,
  output logic [1:0]                slv_error_o,
  input  logic [1:0]                slv_ack_i,
  output logic                      mst_sync_o,
  output logic [MST_WIDTH-1:0]      mst_lvl_o,
  input  logic                      mst_wake_i,
  input  logic                      mst_error_i,
  output logic                      mst_ack_o
);

  typedef enum logic [2:0] {IDLE, JOIN, DECIDE, UP, WAKE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                arrived_q;
  logic [1:0][SLV_WIDTH-1:0] lvl_q;

  logic                      lvl_bad;
  logic                      lvl_local;
  logic [1:0]                ack_vld;
  logic                      release_barrier;

  logic [1:0]                wake_d;
  logic [1:0]                error_d;
  logic                      mst_sync_d;
  logic [MST_WIDTH-1:0]      mst_lvl_d;
  logic                      mst_ack_d;

  function automatic logic is_onehot(input logic [SLV_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - SLV_WIDTH'(1))) == '0);
  endfunction

  // Both children must agree on a single valid level; bit 0 means this node is the barrier owner.
  assign lvl_bad         = (lvl_q[0] != lvl_q[1]) || !is_onehot(lvl_q[0]);
  assign lvl_local       = lvl_q[0][0];
  // An ack only counts while that child is actually being woken.
  assign ack_vld         = slv_ack_i & slv_wake_o;
  assign release_barrier = (state_q == WAKE) && ((slv_wake_o & ~ack_vld) == 2'b00);

  // Latch each child's first sync and its level; a child already counted is ignored until release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arrived_q <= '0;
      lvl_q     <= '0;
    end else if (release_barrier) begin
      arrived_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (slv_sync_i[i] && !arrived_q[i]) begin
          arrived_q[i] <= 1'b1;
          lvl_q[i]     <= slv_lvl_i[i];
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      slv_wake_o  <= '0;
      slv_error_o <= '0;
      mst_sync_o  <= 1'b0;
      mst_lvl_o   <= '0;
      mst_ack_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slv_wake_o  <= wake_d;
      slv_error_o <= error_d;
      mst_sync_o  <= mst_sync_d;
      mst_lvl_o   <= mst_lvl_d;
      mst_ack_o   <= mst_ack_d;
    end
  end

  // Next state: simultaneous arrival skips JOIN so it times exactly like a staggered one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (&arrived_q)      state_d = DECIDE;
        else if (|arrived_q) state_d = JOIN;
      end
      JOIN: begin
        if (&arrived_q) state_d = DECIDE;
      end
      DECIDE: begin
        if (lvl_bad || lvl_local) state_d = WAKE;
        else                      state_d = UP;
      end
      UP: begin
        if (mst_wake_i) state_d = WAKE;
      end
      WAKE: begin
        if (release_barrier) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next output values: decide wake/forward, answer the parent, retire each child's wake on its ack.
  always_comb begin
    wake_d     = slv_wake_o;
    error_d    = slv_error_o;
    mst_sync_d = mst_sync_o;
    mst_lvl_d  = mst_lvl_o;
    mst_ack_d  = 1'b0;
    case (state_q)
      DECIDE: begin
        if (lvl_bad) begin
          wake_d  = 2'b11;
          error_d = 2'b11;
        end else if (lvl_local) begin
          wake_d  = 2'b11;
          error_d = 2'b00;
        end else begin
          mst_sync_d = 1'b1;
          mst_lvl_d  = lvl_q[0][SLV_WIDTH-1:1];
        end
      end
      UP: begin
        if (mst_wake_i) begin
          mst_sync_d = 1'b0;
          mst_lvl_d  = '0;
          mst_ack_d  = 1'b1;
          wake_d     = 2'b11;
          error_d    = {2{mst_error_i}};
        end
      end
      WAKE: begin
        wake_d  = slv_wake_o & ~ack_vld;
        error_d = slv_error_o & ~ack_vld;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fractal_sync_node.sv
// Two-level sync tree: two leaves (SLV_WIDTH=3) under one root (SLV_WIDTH=2).
// Four compute-unit requesters and the root's parent terminator are modelled at the falling edge.
// Each scenario task compares observed behaviour against hand-derived expectations.
module tb_fractal_sync_node;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      cu_sync;
  logic [3:0]      cu_ack;
  logic [3:0][2:0] cu_lvl;
  logic [3:0]      cu_wake;
  logic [3:0]      cu_err;
  logic [1:0]      lf0_wake, lf0_err, lf1_wake, lf1_err;
  logic            l_sync0, l_sync1, l_ack0, l_ack1;
  logic [1:0]      l_lvl0, l_lvl1;
  logic [1:0]      r_wake, r_err;
  logic            root_sync, root_ack;
  logic [0:0]      root_lvl;
  logic            term_wake, term_err;

  assign cu_wake = {lf1_wake, lf0_wake};
  assign cu_err  = {lf1_err, lf0_err};

  fractal_sync_node #(.SLV_WIDTH(3)) u_leaf0 (
    .clk_i(clk), .rst_i(rst),
    .slv_sync_i(cu_sync[1:0]), .slv_lvl_i(cu_lvl[1:0]),
    .slv_wake_o(lf0_wake), .slv_error_o(lf0_err), .slv_ack_i(cu_ack[1:0]),
    .mst_sync_o(l_sync0), .mst_lvl_o(l_lvl0),
    .mst_wake_i(r_wake[0]), .mst_error_i(r_err[0]), .mst_ack_o(l_ack0)
  );

  fractal_sync_node #(.SLV_WIDTH(3)) u_leaf1 (
    .clk_i(clk), .rst_i(rst),
    .slv_sync_i(cu_sync[3:2]), .slv_lvl_i(cu_lvl[3:2]),
    .slv_wake_o(lf1_wake), .slv_error_o(lf1_err), .slv_ack_i(cu_ack[3:2]),
    .mst_sync_o(l_sync1), .mst_lvl_o(l_lvl1),
    .mst_wake_i(r_wake[1]), .mst_error_i(r_err[1]), .mst_ack_o(l_ack1)
  );

  fractal_sync_node #(.SLV_WIDTH(2)) u_root (
    .clk_i(clk), .rst_i(rst),
    .slv_sync_i({l_sync1, l_sync0}), .slv_lvl_i({l_lvl1, l_lvl0}),
    .slv_wake_o(r_wake), .slv_error_o(r_err), .slv_ack_i({l_ack1, l_ack0}),
    .mst_sync_o(root_sync), .mst_lvl_o(root_lvl),
    .mst_wake_i(term_wake), .mst_error_i(term_err), .mst_ack_o(root_ack)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         rise_cyc [4];
  int         wake_cyc [4];
  int         wake_cnt [4];
  int         start_at [4];
  logic [3:0] pending;
  logic [3:0] last_err;
  logic [3:0] err_or;
  int         spurious;
  logic [1:0] l_sync_seen;
  logic [1:0] l_lvl0_seen;
  logic       root_sync_seen;
  logic       root_lvl_seen;
  int         term_cnt;

  function automatic logic [22:0] outs_vec();
    return {lf0_wake, lf0_err, lf1_wake, lf1_err, l_sync0, l_sync1, l_ack0, l_ack1,
            r_wake, r_err, root_sync, root_ack, l_lvl0, l_lvl1, root_lvl};
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      rise_cyc[i] = 0;
      wake_cyc[i] = 0;
      wake_cnt[i] = 0;
    end
    last_err       = '0;
    err_or         = '0;
    spurious       = 0;
    l_sync_seen    = '0;
    l_lvl0_seen    = '0;
    root_sync_seen = 1'b0;
    root_lvl_seen  = 1'b0;
  endtask

  task automatic clear_requesters();
    cu_sync   = '0;
    cu_ack    = '0;
    pending   = '0;
    term_wake = 1'b0;
    term_err  = 1'b0;
    term_cnt  = 0;
  endtask

  // One cycle: advance to the falling edge, observe, then run the requester and terminator models.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (root_sync) begin
      root_sync_seen = 1'b1;
      root_lvl_seen  = root_lvl[0];
    end
    if (l_sync0) begin
      l_sync_seen[0] = 1'b1;
      l_lvl0_seen    = l_lvl0;
    end
    if (l_sync1) l_sync_seen[1] = 1'b1;
    if (term_wake) begin
      if (root_ack) begin
        term_wake = 1'b0;
        term_err  = 1'b0;
        term_cnt  = 0;
      end
    end else if (root_sync) begin
      term_cnt++;
      if (term_cnt >= 2) begin
        term_wake = 1'b1;
        term_err  = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      cu_ack[i] = 1'b0;
      if (cu_wake[i] && !cu_sync[i]) spurious++;
      if (cu_sync[i] && cu_wake[i]) begin
        cu_sync[i]  = 1'b0;
        cu_ack[i]   = 1'b1;
        wake_cnt[i] = wake_cnt[i] + 1;
        wake_cyc[i] = cyc;
        last_err[i] = cu_err[i];
        err_or[i]   = err_or[i] | cu_err[i];
      end else if (pending[i] && cyc >= start_at[i]) begin
        cu_sync[i]  = 1'b1;
        pending[i]  = 1'b0;
        rise_cyc[i] = cyc;
      end
    end
  endtask

  // Arm the masked requesters with random start skew and wait (bounded) until each is woken once.
  task automatic run_barrier(input logic [3:0] mask, input logic [3:0][2:0] lvl,
                             input int lo, input int hi, output logic done);
    int base [4];
    for (int i = 0; i < 4; i++) begin
      base[i] = wake_cnt[i];
      if (mask[i]) begin
        cu_lvl[i]   = lvl[i];
        pending[i]  = 1'b1;
        start_at[i] = cyc + 1 + int'($urandom_range(hi, lo));
      end
    end
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      step();
      done = 1'b1;
      for (int i = 0; i < 4; i++)
        if (mask[i] && wake_cnt[i] == base[i]) done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [22:0] o;
    rst = 1'b1;
    step();
    step();
    o = outs_vec();
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    rst = 1'b0;
    step();
    o = outs_vec();
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: got %h want 0", o);
    end
  endtask

  task automatic test_local();
    logic            done;
    logic [3:0][2:0] l;
    int              exp_cyc;
    clear_stats();
    l = {4{3'b001}};
    run_barrier(4'b1111, l, 10, 100, done);
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL local_done: got timeout want all woken");
    end
    for (int i = 0; i < 4; i++) begin
      exp_cyc = (rise_cyc[i & 2] > rise_cyc[i | 1]) ? rise_cyc[i & 2] : rise_cyc[i | 1];
      exp_cyc = exp_cyc + 3;
      tests++;
      if (wake_cnt[i] != 1 || last_err[i] !== 1'b0) begin
        fails++;
        $display("FAIL local_wake cu%0d: got cnt=%0d err=%b want cnt=1 err=0", i, wake_cnt[i], last_err[i]);
      end
      tests++;
      if (wake_cyc[i] != exp_cyc) begin
        fails++;
        $display("FAIL local_latency cu%0d: got cycle %0d want %0d", i, wake_cyc[i], exp_cyc);
      end
    end
    tests++;
    if (root_sync_seen !== 1'b0 || l_sync_seen !== 2'b00) begin
      fails++;
      $display("FAIL local_no_forward: got root=%b leaves=%b want 0/00", root_sync_seen, l_sync_seen);
    end
  endtask

  task automatic test_forward_local();
    logic            done;
    logic [3:0][2:0] l;
    clear_stats();
    l = {4{3'b010}};
    run_barrier(4'b1111, l, 10, 60, done);
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL fwd_done: got timeout want all woken");
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wake_cnt[i] != 1 || last_err[i] !== 1'b0) begin
        fails++;
        $display("FAIL fwd_wake cu%0d: got cnt=%0d err=%b want cnt=1 err=0", i, wake_cnt[i], last_err[i]);
      end
    end
    tests++;
    if (l_sync_seen !== 2'b11 || l_lvl0_seen !== 2'b01) begin
      fails++;
      $display("FAIL fwd_leaf_up: got sync=%b lvl=%b want 11/01", l_sync_seen, l_lvl0_seen);
    end
    tests++;
    if (root_sync_seen !== 1'b0) begin
      fails++;
      $display("FAIL fwd_root_local: got root sync=%b want 0", root_sync_seen);
    end
  endtask

  task automatic test_root_up();
    logic            done;
    logic [3:0][2:0] l;
    clear_stats();
    l = {4{3'b100}};
    run_barrier(4'b1111, l, 2, 20, done);
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL root_up_done: got timeout want all woken");
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wake_cnt[i] != 1 || last_err[i] !== 1'b1) begin
        fails++;
        $display("FAIL root_up_wake cu%0d: got cnt=%0d err=%b want cnt=1 err=1", i, wake_cnt[i], last_err[i]);
      end
    end
    tests++;
    if (root_sync_seen !== 1'b1 || root_lvl_seen !== 1'b1 || l_lvl0_seen !== 2'b10) begin
      fails++;
      $display("FAIL root_up_levels: got root=%b rlvl=%b llvl=%b want 1/1/10",
               root_sync_seen, root_lvl_seen, l_lvl0_seen);
    end
  endtask

  task automatic test_mismatch();
    logic [2:0]      lv_a [3];
    logic [2:0]      lv_b [3];
    logic            done;
    logic [3:0][2:0] l;
    lv_a[0] = 3'b001; lv_b[0] = 3'b010;
    lv_a[1] = 3'b011; lv_b[1] = 3'b011;
    lv_a[2] = 3'b000; lv_b[2] = 3'b000;
    for (int k = 0; k < 3; k++) begin
      clear_stats();
      l    = '0;
      l[0] = lv_a[k];
      l[1] = lv_b[k];
      run_barrier(4'b0011, l, 1, 15, done);
      tests++;
      if (!done || wake_cnt[0] != 1 || wake_cnt[1] != 1 || last_err[1:0] !== 2'b11) begin
        fails++;
        $display("FAIL mismatch_wake case%0d: got done=%b cnt=%0d/%0d err=%b want 1 1/1 11",
                 k, done, wake_cnt[0], wake_cnt[1], last_err[1:0]);
      end
      tests++;
      if (l_sync_seen[0] !== 1'b0) begin
        fails++;
        $display("FAIL mismatch_no_up case%0d: got leaf sync=%b want 0", k, l_sync_seen[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic            done;
    logic            up_seen;
    logic [22:0]     o;
    logic [3:0][2:0] l;
    // Abort while leaf0 waits in JOIN with a single arrival.
    clear_stats();
    cu_lvl[0]   = 3'b001;
    pending[0]  = 1'b1;
    start_at[0] = cyc + 1;
    for (int n = 0; n < 5; n++) step();
    rst = 1'b1;
    clear_requesters();
    step();
    o = outs_vec();
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_in_join: got %h want 0", o);
    end
    rst = 1'b0;
    step();
    step();
    l = {4{3'b001}};
    run_barrier(4'b0011, l, 0, 5, done);
    tests++;
    if (!done || wake_cnt[0] != 1 || wake_cnt[1] != 1 || last_err[1:0] !== 2'b00) begin
      fails++;
      $display("FAIL after_join_reset: got done=%b cnt=%0d/%0d err=%b want 1 1/1 00",
               done, wake_cnt[0], wake_cnt[1], last_err[1:0]);
    end
    // Abort while leaf0 holds its parent request in UP.
    clear_stats();
    cu_lvl[0] = 3'b010;
    cu_lvl[1] = 3'b010;
    pending[1:0] = 2'b11;
    start_at[0]  = cyc + 1;
    start_at[1]  = cyc + 3;
    up_seen = 1'b0;
    for (int n = 0; n < 50 && !up_seen; n++) begin
      step();
      up_seen = l_sync_seen[0];
    end
    tests++;
    if (up_seen !== 1'b1) begin
      fails++;
      $display("FAIL reach_up: got leaf sync=%b want 1", up_seen);
    end
    rst = 1'b1;
    clear_requesters();
    step();
    o = outs_vec();
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_in_up: got %h want 0", o);
    end
    rst = 1'b0;
    step();
    step();
    l = {4{3'b010}};
    run_barrier(4'b1111, l, 0, 8, done);
    tests++;
    if (!done || wake_cnt[0] != 1 || wake_cnt[1] != 1 || wake_cnt[2] != 1 || wake_cnt[3] != 1
        || err_or !== 4'b0000) begin
      fails++;
      $display("FAIL after_up_reset: got done=%b cnt=%0d%0d%0d%0d err=%b want 1 1111 0000",
               done, wake_cnt[0], wake_cnt[1], wake_cnt[2], wake_cnt[3], err_or);
    end
  endtask

  task automatic test_back_to_back();
    logic            done;
    logic [3:0][2:0] l;
    logic [2:0]      lv;
    int              timeouts;
    clear_stats();
    timeouts = 0;
    for (int k = 0; k < 10; k++) begin
      lv = ($urandom_range(1, 0) == 1) ? 3'b010 : 3'b001;
      l  = {4{lv}};
      run_barrier(4'b1111, l, 0, 3, done);
      if (!done) timeouts++;
    end
    tests++;
    if (timeouts != 0) begin
      fails++;
      $display("FAIL b2b_timeouts: got %0d want 0", timeouts);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wake_cnt[i] != 10) begin
        fails++;
        $display("FAIL b2b_count cu%0d: got %0d want 10", i, wake_cnt[i]);
      end
    end
    tests++;
    if (err_or !== 4'b0000 || spurious != 0) begin
      fails++;
      $display("FAIL b2b_clean: got err=%b spurious=%0d want 0000/0", err_or, spurious);
    end
  endtask

  initial begin
    cu_lvl = '0;
    clear_requesters();
    clear_stats();
    #1 rst = 1'b1;
    test_reset();
    test_local();
    test_forward_local();
    test_root_up();
    test_mismatch();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
